// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// States, fault causes, reset NOP and PC increment.
package fetch_pkg;

   typedef enum logic [2:0] {
      REQ,
      WAIT,
      DROP,
      DELIVER,
      FAULT
   } fetch_state_e;

   typedef enum logic [1:0] {
      CAUSE_NONE    = 2'd0,
      CAUSE_MISALIGN = 2'd1,
      CAUSE_BUSERR  = 2'd2
   } fetch_cause_e;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam int unsigned PC_STEP   = 4;

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: req/gnt/rvalid memory side, valid/ready
// decode side, next-PC generation, redirects and fetch faults.
module if_fetch_unit #(
   parameter int unsigned       DWIDTH    = 32,
   parameter logic [DWIDTH-1:0] NOP_INSTR = DWIDTH'(fetch_pkg::NOP_INSTR)
) (
   input  logic              Clk,
   input  logic              N_Rst,
   input  logic [DWIDTH-1:0] pc_i,
   output logic [DWIDTH-1:0] pc_next_o,
   input  logic              redirect_i,
   input  logic [DWIDTH-1:0] redirect_target_i,
   output logic              imem_req_o,
   output logic [DWIDTH-1:0] imem_addr_o,
   input  logic              imem_gnt_i,
   input  logic              imem_rvalid_i,
   input  logic [DWIDTH-1:0] imem_rdata_i,
   input  logic              imem_err_i,
   output logic              instr_valid_o,
   input  logic              instr_ready_i,
   output logic [DWIDTH-1:0] instr_o,
   output logic [DWIDTH-1:0] instr_pc_o,
   output logic              fault_o,
   output logic [1:0]        fault_cause_o
);

   import fetch_pkg::*;

   fetch_state_e      r_state;
   fetch_state_e      w_next;
   fetch_cause_e      r_cause;
   logic [DWIDTH-1:0] r_instr;
   logic [DWIDTH-1:0] r_instr_pc;
   logic [DWIDTH-1:0] w_pc_next;
   logic              w_req;
   logic              w_valid;
   logic              w_fault;
   logic              w_misalign;

   assign w_misalign = (pc_i[1:0] != 2'b00);

   always_comb begin
      w_next    = r_state;
      w_pc_next = pc_i;
      w_req     = 1'b0;
      w_valid   = 1'b0;
      w_fault   = 1'b0;
      unique case (r_state)
         REQ: begin
            if (w_misalign) begin
               w_next = FAULT;
            end else begin
               w_req = 1'b1;
               if (imem_gnt_i) w_next = WAIT;
            end
         end
         WAIT: begin
            if (imem_rvalid_i)
               w_next = imem_err_i ? FAULT : DELIVER;
         end
         DROP: begin
            if (imem_rvalid_i) w_next = REQ;
         end
         DELIVER: begin
            w_valid = 1'b1;
            if (instr_ready_i) begin
               w_pc_next = pc_i + DWIDTH'(PC_STEP);
               w_next    = REQ;
            end
         end
         FAULT: begin
            w_fault = 1'b1;
         end
         default: w_next = REQ;
      endcase
      // A granted fetch must have its response drained before refetching
      if (redirect_i) begin
         w_pc_next = redirect_target_i;
         if ((r_state == WAIT && !imem_rvalid_i) ||
             (r_state == DROP && !imem_rvalid_i) ||
             (w_req && imem_gnt_i))
            w_next = DROP;
         else
            w_next = REQ;
      end
   end

   always_ff @(posedge Clk or negedge N_Rst) begin
      if (!N_Rst) begin
         r_state    <= REQ;
         r_cause    <= CAUSE_NONE;
         r_instr    <= NOP_INSTR;
         r_instr_pc <= '0;
      end else begin
         r_state <= w_next;
         if (redirect_i) begin
            r_instr <= NOP_INSTR;
            r_cause <= CAUSE_NONE;
         end else if (r_state == REQ && w_misalign) begin
            r_cause <= CAUSE_MISALIGN;
         end else if (r_state == WAIT && imem_rvalid_i) begin
            r_instr_pc <= pc_i;
            if (imem_err_i) r_cause <= CAUSE_BUSERR;
            else            r_instr <= imem_rdata_i;
         end
      end
   end

   assign pc_next_o     = w_pc_next;
   assign imem_req_o    = w_req & N_Rst;
   assign imem_addr_o   = pc_i;
   assign instr_valid_o = w_valid & N_Rst;
   assign fault_o       = w_fault & N_Rst;
   assign instr_o       = r_instr;
   assign instr_pc_o    = r_instr_pc;
   assign fault_cause_o = r_cause;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a modelled PC register.
// Memory handshake is driven by hand in each scenario task.
module tb_if_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        Clk;
   logic        N_Rst;
   logic [31:0] pc_q;
   logic [31:0] pc_next_o;
   logic        redirect_i;
   logic [31:0] redirect_target_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        imem_err_i;
   logic        instr_valid_o;
   logic        instr_ready_i;
   logic [31:0] instr_o;
   logic [31:0] instr_pc_o;
   logic        fault_o;
   logic [1:0]  fault_cause_o;

   int errs = 0;
   int checks = 0;

   if_fetch_unit dut (
      .Clk(Clk), .N_Rst(N_Rst), .pc_i(pc_q), .pc_next_o(pc_next_o),
      .redirect_i(redirect_i), .redirect_target_i(redirect_target_i),
      .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
      .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i),
      .imem_rdata_i(imem_rdata_i), .imem_err_i(imem_err_i),
      .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
      .instr_o(instr_o), .instr_pc_o(instr_pc_o),
      .fault_o(fault_o), .fault_cause_o(fault_cause_o)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // PC register loads PCin on every edge
   always @(posedge Clk or negedge N_Rst) begin
      if (!N_Rst) pc_q <= '0;
      else        pc_q <= pc_next_o;
   end

   task automatic step;
      @(posedge Clk);
      #1;
   endtask

   task automatic idle_in;
      redirect_i = 0; imem_gnt_i = 0; imem_rvalid_i = 0; imem_err_i = 0;
   endtask

   task automatic test_reset;
      N_Rst = 0; idle_in(); instr_ready_i = 0;
      redirect_target_i = 0; imem_rdata_i = 0;
      #12;
      checks++; if (imem_req_o !== 1'b0) begin errs++; $display("FAIL rst_req got=%b exp=0", imem_req_o); end
      checks++; if (instr_valid_o !== 1'b0) begin errs++; $display("FAIL rst_valid got=%b exp=0", instr_valid_o); end
      checks++; if (fault_o !== 1'b0) begin errs++; $display("FAIL rst_fault got=%b exp=0", fault_o); end
      checks++; if (instr_o !== NOP) begin errs++; $display("FAIL rst_instr got=%h exp=%h", instr_o, NOP); end
      checks++; if (instr_pc_o !== 32'h0) begin errs++; $display("FAIL rst_ipc got=%h exp=0", instr_pc_o); end
      checks++; if (fault_cause_o !== 2'd0) begin errs++; $display("FAIL rst_cause got=%0d exp=0", fault_cause_o); end
      step();
      N_Rst = 1;
   endtask

   task automatic test_zero_wait;
      instr_ready_i = 1; imem_gnt_i = 1; #1;
      checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin errs++; $display("FAIL zw_req got=%b/%h exp=1/0", imem_req_o, imem_addr_o); end
      checks++; if (pc_next_o !== 32'h0) begin errs++; $display("FAIL zw_stall got=%h exp=0", pc_next_o); end
      step();
      imem_gnt_i = 0; imem_rvalid_i = 1; imem_rdata_i = 32'h0050_0093; #1;
      checks++; if (instr_valid_o !== 1'b0) begin errs++; $display("FAIL zw_c1_valid got=%b exp=0", instr_valid_o); end
      step();
      imem_rvalid_i = 0; #1;
      checks++; if (instr_valid_o !== 1'b1) begin errs++; $display("FAIL zw_c2_valid got=%b exp=1", instr_valid_o); end
      checks++; if (instr_o !== 32'h0050_0093) begin errs++; $display("FAIL zw_instr got=%h exp=00500093", instr_o); end
      checks++; if (instr_pc_o !== 32'h0) begin errs++; $display("FAIL zw_ipc got=%h exp=0", instr_pc_o); end
      checks++; if (pc_next_o !== 32'h4) begin errs++; $display("FAIL zw_pcnext got=%h exp=4", pc_next_o); end
      step();
      instr_ready_i = 0; #1;
      checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h4) begin errs++; $display("FAIL zw_c3_req got=%b/%h exp=1/4", imem_req_o, imem_addr_o); end
      checks++; if (instr_valid_o !== 1'b0) begin errs++; $display("FAIL zw_c3_valid got=%b exp=0", instr_valid_o); end
   endtask

   task automatic test_stalls;
      for (int i = 0; i < 3; i++) begin
         checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h4 || pc_next_o !== 32'h4) begin errs++; $display("FAIL st_gnt%0d got=%b/%h/%h exp=1/4/4", i, imem_req_o, imem_addr_o, pc_next_o); end
         step(); #1;
      end
      imem_gnt_i = 1; #1;
      step();
      imem_gnt_i = 0; #1;
      checks++; if (imem_req_o !== 1'b0 || imem_addr_o !== 32'h4 || pc_next_o !== 32'h4) begin errs++; $display("FAIL st_wait got=%b/%h/%h exp=0/4/4", imem_req_o, imem_addr_o, pc_next_o); end
      step();
      imem_rvalid_i = 1; imem_rdata_i = 32'h00A0_0113; #1;
      step();
      imem_rvalid_i = 0; #1;
      for (int i = 0; i < 4; i++) begin
         checks++; if (instr_valid_o !== 1'b1 || instr_o !== 32'h00A0_0113 || instr_pc_o !== 32'h4 || pc_next_o !== 32'h4) begin errs++; $display("FAIL st_hold%0d got=%b/%h/%h/%h", i, instr_valid_o, instr_o, instr_pc_o, pc_next_o); end
         step(); #1;
      end
      instr_ready_i = 1; #1;
      checks++; if (pc_next_o !== 32'h8) begin errs++; $display("FAIL st_accept got=%h exp=8", pc_next_o); end
      step();
      instr_ready_i = 0; #1;
      checks++; if (imem_addr_o !== 32'h8 || imem_req_o !== 1'b1) begin errs++; $display("FAIL st_next got=%b/%h exp=1/8", imem_req_o, imem_addr_o); end
   endtask

   task automatic test_redirect_wait;
      imem_gnt_i = 1; #1;
      step();
      imem_gnt_i = 0; redirect_i = 1; redirect_target_i = 32'h100; #1;
      checks++; if (pc_next_o !== 32'h100) begin errs++; $display("FAIL rw_pcnext got=%h exp=100", pc_next_o); end
      step();
      redirect_i = 0; #1;
      checks++; if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b0 || instr_o !== NOP) begin errs++; $display("FAIL rw_drop got=%b/%b/%h", imem_req_o, instr_valid_o, instr_o); end
      step();
      imem_rvalid_i = 1; imem_rdata_i = 32'hDEAD_BEEF; #1;
      checks++; if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b0) begin errs++; $display("FAIL rw_drain got=%b/%b exp=0/0", imem_req_o, instr_valid_o); end
      step();
      imem_rvalid_i = 0; #1;
      checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100 || instr_valid_o !== 1'b0 || instr_o !== NOP) begin errs++; $display("FAIL rw_refetch got=%b/%h/%b/%h", imem_req_o, imem_addr_o, instr_valid_o, instr_o); end
   endtask

   task automatic test_misalign;
      redirect_i = 1; redirect_target_i = 32'h102; #1;
      step();
      redirect_i = 0; #1;
      checks++; if (imem_req_o !== 1'b0 || fault_o !== 1'b0) begin errs++; $display("FAIL ma_noreq got=%b/%b exp=0/0", imem_req_o, fault_o); end
      step();
      for (int i = 0; i < 2; i++) begin
         checks++; if (fault_o !== 1'b1 || fault_cause_o !== 2'd1 || imem_req_o !== 1'b0 || pc_next_o !== 32'h102) begin errs++; $display("FAIL ma_fault%0d got=%b/%0d/%b/%h", i, fault_o, fault_cause_o, imem_req_o, pc_next_o); end
         step(); #1;
      end
      redirect_i = 1; redirect_target_i = 32'h200; #1;
      checks++; if (pc_next_o !== 32'h200) begin errs++; $display("FAIL ma_redir got=%h exp=200", pc_next_o); end
      step();
      redirect_i = 0; #1;
      checks++; if (fault_o !== 1'b0 || fault_cause_o !== 2'd0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h200) begin errs++; $display("FAIL ma_exit got=%b/%0d/%b/%h", fault_o, fault_cause_o, imem_req_o, imem_addr_o); end
   endtask

   task automatic test_bus_error;
      redirect_i = 1; redirect_target_i = 32'h40; #1;
      step();
      redirect_i = 0; imem_gnt_i = 1; #1;
      step();
      imem_gnt_i = 0; imem_rvalid_i = 1; imem_err_i = 1; imem_rdata_i = 32'hBAD0_BAD0; #1;
      step();
      imem_rvalid_i = 0; imem_err_i = 0; #1;
      checks++; if (fault_o !== 1'b1 || fault_cause_o !== 2'd2) begin errs++; $display("FAIL be_fault got=%b/%0d exp=1/2", fault_o, fault_cause_o); end
      checks++; if (instr_pc_o !== 32'h40 || instr_valid_o !== 1'b0) begin errs++; $display("FAIL be_ipc got=%h/%b exp=40/0", instr_pc_o, instr_valid_o); end
      redirect_i = 1; redirect_target_i = 32'hFFFF_FFFC; #1;
      step();
      redirect_i = 0; #1;
   endtask

   task automatic test_wrap_and_reset;
      checks++; if (imem_addr_o !== 32'hFFFF_FFFC || imem_req_o !== 1'b1) begin errs++; $display("FAIL wr_req got=%b/%h", imem_req_o, imem_addr_o); end
      imem_gnt_i = 1; #1;
      step();
      imem_gnt_i = 0; imem_rvalid_i = 1; imem_rdata_i = 32'h0000_0073; #1;
      step();
      imem_rvalid_i = 0; instr_ready_i = 1; #1;
      checks++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'hFFFF_FFFC || pc_next_o !== 32'h0) begin errs++; $display("FAIL wr_wrap got=%b/%h/%h exp=1/fffffffc/0", instr_valid_o, instr_pc_o, pc_next_o); end
      step();
      instr_ready_i = 0; #1;
      checks++; if (imem_addr_o !== 32'h0) begin errs++; $display("FAIL wr_addr got=%h exp=0", imem_addr_o); end
      imem_gnt_i = 1; #1;
      step();
      imem_gnt_i = 0; imem_rvalid_i = 1; imem_rdata_i = 32'h1234_5678; #1;
      step();
      imem_rvalid_i = 0; #1;
      checks++; if (instr_valid_o !== 1'b1 || instr_o !== 32'h1234_5678) begin errs++; $display("FAIL rd_deliver got=%b/%h", instr_valid_o, instr_o); end
      N_Rst = 0; #1;
      checks++; if (instr_valid_o !== 1'b0 || instr_o !== NOP || imem_req_o !== 1'b0 || instr_pc_o !== 32'h0) begin errs++; $display("FAIL rd_reset got=%b/%h/%b/%h", instr_valid_o, instr_o, imem_req_o, instr_pc_o); end
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_stalls();
      test_redirect_wait();
      test_misalign();
      test_bus_error();
      test_wrap_and_reset();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
